// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one difference bit per clock, LSB first, z = x - y mod 2^WIDTH.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             b_q, b_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             xs_q, xs_d;
  logic             ys_q, ys_d;
  logic             ovf_q, ovf_d;
`endif

  logic xi, yi, d_bit, b_bit, last_bit;

  // Full subtractor on the current LSBs of the operand shift registers.
  assign xi       = x_q[0];
  assign yi       = y_q[0];
  assign d_bit    = xi ^ yi ^ b_q;
  assign b_bit    = (~xi & yi) | (~(xi ^ yi) & b_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    xs_d    = xs_q;
    ys_d    = ys_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          x_d     = x;
          y_d     = y;
          z_d     = '0;
          cnt_d   = '0;
          b_d     = 1'b0;
          bout_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          xs_d    = x[WIDTH-1];
          ys_d    = y[WIDTH-1];
          ovf_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        x_d = x_q >> 1;
        y_d = y_q >> 1;
        z_d = {d_bit, z_q[WIDTH-1:1]};
        b_d = b_bit;
        if (last_bit) begin
          // The bit computed now becomes z[MSB], so overflow is judged on d_bit.
          state_d = S_DONE;
          bout_d  = b_bit;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (xs_q != ys_q) && (d_bit != xs_q);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      b_q     <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign z    = z_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port x, input, WIDTH bits: minuend, captured when start is accepted.
REQ-006 The block SHALL have port y, input, WIDTH bits: subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 The block SHALL have port z, output, WIDTH bits: difference x-y modulo 2^WIDTH.
REQ-010 The block SHALL have port bout, output, 1 bit: final borrow, high when unsigned x < y.

Function
REQ-011 The FSM SHALL have three states, IDLE, RUN and DONE; transitions: IDLE->RUN on start=1, RUN->DONE when the bit counter equals WIDTH-1, and DONE->IDLE unconditionally.
REQ-012 When start is accepted, the block SHALL capture x and y into shift registers, clear the borrow flop to 0, clear the bit counter to 0, and clear the z register to 0.
REQ-013 Each RUN cycle SHALL process bit i = counter, LSB first, using a one-bit full-subtractor: d = xi^yi^b; b_next = (~xi&yi) | (~(xi^yi)&b).
REQ-014 d SHALL be shifted into z at the MSB while z shifts right; after WIDTH RUN cycles, z[i] SHALL hold the difference bit i.
REQ-015 Latency: if start is accepted at edge k, the block SHALL be in DONE after edge k+WIDTH, and done SHALL be high for exactly that one cycle.
REQ-016 z and bout SHALL remain stable from entry to DONE until the next accepted start.
REQ-017 start SHALL be ignored in RUN and DONE; x and y changes after capture SHALL have no effect.
REQ-018 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE); both SHALL be registered-state decodes.
REQ-019 Back-to-back operation: start held high SHALL begin a new operation in the IDLE cycle following DONE, one operation per WIDTH+2 cycles.
REQ-020 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap inside an operation.

Reset
REQ-021 When rst_n=0, the block SHALL enter IDLE immediately and SHALL drive busy=0, done=0, z=0, bout=0 and ovf=0, with the operand registers and counter cleared.
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the block SHALL accept start on the first rising edge.

Configuration
REQ-023 With macro SERIAL_SUB_OVF_EN defined, the block SHALL add port ovf, output, 1 bit: signed overflow, registered on entry to DONE as (x[MSB]!=y[MSB]) && (z[MSB]!=x[MSB]), and held like z.
REQ-024 Without SERIAL_SUB_OVF_EN, the ovf port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-025 Basic subtract: WIDTH=32, x=5, y=3, start pulse -> done exactly 32 cycles after the accept edge, z=0x00000002, bout=0.
REQ-026 Borrow: x=3, y=5 -> z=0xFFFFFFFE, bout=1; with SERIAL_SUB_OVF_EN, ovf=0.
REQ-027 Signed overflow: x=0x80000000, y=1 -> z=0x7FFFFFFF, bout=0, ovf=1; x=0, y=0 -> z=0, bout=0, ovf=0.
REQ-028 Ignore start: start re-pulsed in RUN with new x/y -> result reflects the first operands only, exactly one done pulse.
REQ-029 Reset mid-op: rst_n low at RUN cycle 10 -> immediate IDLE, outputs 0, no done; a new op (x=10, y=4) then completes with z=6.
REQ-030 Back-to-back: start held high for two ops (7-2, then 2-7) -> done pulses 34 cycles apart, z=5 then 0xFFFFFFFB with bout=1.
